// File: rtl/vga_scanout_pkg.sv
// Shared VGA geometry, bus widths and framebuffer addressing for the scanout path.
// Draw-side logic imports this package so both sides agree on screen and framebuffer layout.
package vga_scanout_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int unsigned SCALE_SHIFT_DEF = 2;
    localparam int unsigned BPC_DEF         = 1;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DAC_W  = 10;

    // Framebuffer is 160 pixels wide: y*160 = (y<<7) + (y<<5), no multiplier.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] x,
                                                  input logic [CNT_W-1:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, horizontal/vertical counters and undelayed sync/visible flags.
// frame_start_o pulses for one clock when the counters wrap to (0,0).
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             pix_tick_o,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             hs_c,
    output logic             vs_c,
    output logic             visible_c,
    output logic             frame_start_o
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);

    logic             pix_tick_q, pix_tick_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             frame_start_q, frame_start_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_tick_q    <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= pix_tick_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Counters step only on pixel ticks; the frame wrap raises frame_start.
    always_comb begin
        pix_tick_d    = ~pix_tick_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (pix_tick_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hs_c      = ~((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
        vs_c      = ~((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
        visible_c = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    end

    assign pix_tick_o    = pix_tick_q;
    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: 160x120 framebuffer scaled 4x to 640x480@60 VGA.
// Address register plus one-cycle RAM latency are matched by a 2-tick sync/blank pipeline.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT         = H_FRONT_DEF,
    parameter int unsigned H_SYNC          = H_SYNC_DEF,
    parameter int unsigned H_BACK          = H_BACK_DEF,
    parameter int unsigned V_VISIBLE       = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT         = V_FRONT_DEF,
    parameter int unsigned V_SYNC          = V_SYNC_DEF,
    parameter int unsigned V_BACK          = V_BACK_DEF,
    parameter int unsigned SCALE_SHIFT     = SCALE_SHIFT_DEF,
    parameter int unsigned BITS_PER_COLOUR = BPC_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [3*BITS_PER_COLOUR-1:0] rd_data,
    output logic                         VGA_CLK,
    output logic                         VGA_HS,
    output logic                         VGA_VS,
    output logic                         VGA_BLANK_N,
    output logic                         VGA_SYNC_N,
    output logic [DAC_W-1:0]             VGA_R,
    output logic [DAC_W-1:0]             VGA_G,
    output logic [DAC_W-1:0]             VGA_B,
    output logic                         frame_start
);

    localparam int unsigned BPC = BITS_PER_COLOUR;

    logic             pix_tick;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hs_c;
    logic             vs_c;
    logic             visible_c;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_i         (clock),
        .rst_i         (reset),
        .pix_tick_o    (pix_tick),
        .hcount_o      (hcount),
        .vcount_o      (vcount),
        .hs_c          (hs_c),
        .vs_c          (vs_c),
        .visible_c     (visible_c),
        .frame_start_o (frame_start)
    );

    // Channel expansion: repeat each channel's bits MSB-first across the DAC width.
    logic [BPC-1:0]   r_raw, g_raw, b_raw;
    logic [DAC_W-1:0] r_exp, g_exp, b_exp;

    assign r_raw = rd_data[3*BPC-1 -: BPC];
    assign g_raw = rd_data[2*BPC-1 -: BPC];
    assign b_raw = rd_data[BPC-1:0];

    for (genvar i = 0; i < DAC_W; i++) begin : g_expand
        assign r_exp[DAC_W-1-i] = r_raw[BPC-1-(i%BPC)];
        assign g_exp[DAC_W-1-i] = g_raw[BPC-1-(i%BPC)];
        assign b_exp[DAC_W-1-i] = b_raw[BPC-1-(i%BPC)];
    end

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic              hs2_q, hs2_d, vs2_q, vs2_d, blank_n_q, blank_n_d;
    logic [DAC_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic              vga_clk_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vis1_q    <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            vis1_q    <= vis1_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            vga_clk_q <= pix_tick;
        end
    end

    // Stage 1 issues the address; stage 2 meets the RAM data one tick later.
    always_comb begin
        addr_d    = addr_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        vis1_d    = vis1_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pix_tick) begin
            hs1_d  = hs_c;
            vs1_d  = vs_c;
            vis1_d = visible_c;
            if (visible_c) begin
                addr_d = fb_addr(hcount >> SCALE_SHIFT, vcount >> SCALE_SHIFT);
            end
            hs2_d     = hs1_q;
            vs2_d     = vs1_q;
            blank_n_d = vis1_q;
            r_d       = vis1_q ? r_exp : '0;
            g_d       = vis1_q ? g_exp : '0;
            b_d       = vis1_q ? b_exp : '0;
        end
    end

    assign rd_addr     = addr_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule
